exception_ctrl: RTL

//  Consumer side of the main decoder's exception signals (NotAnInstr, ERet) in the

---
 rtl/exception_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/exception_ctrl.sv
// exception_ctrl: receives the main decoder's exception signals for the single-cycle LEGv8 core.
//
// Events:
//   - An invalid opcode (NotAnInstr) redirects the PC to exc_vector in the same cycle.
//   - An external interrupt (ext_irq) does the same, but only in NORMAL.
//   - On either event the PC (elr) and the cause (esr) are captured, and the saturating
//     exception counter ERR is incremented.
//   - ERET returns from HANDLER to NORMAL. The core takes elr as the next PC.
//   - MRS reads ELR, ESR or ERR through sys_sel/sys_rd.
//
// Ports:
//   clk, reset      core clock and synchronous active-high reset
//   pc_i            PC of the instruction executing this cycle
//   NotAnInstr      decoder: opcode not recognised
//   ERet            decoder: ERET executing
//   ext_irq         level interrupt request, held until ext_iack
//   sys_sel         MRS select: 00 ELR, 01 ESR, 10 ERR, 11 zero
//   exc             combinational PC redirect to exc_vector
//   exc_vector      constant handler entry address
//   elr, esr        exception link register and syndrome
//   ext_iack        one-cycle registered interrupt acknowledge
//   in_handler      high while in HANDLER
//   double_fault    sticky: invalid opcode seen while in HANDLER
//   sys_rd          combinational MRS read data
module exception_ctrl #(
  parameter int unsigned  N          = 64,
  parameter logic [N-1:0] EXC_VECTOR = 64'hD8,
  parameter int unsigned  CNT_W      = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pc_i,
  input  logic         NotAnInstr,
  input  logic         ERet,
  input  logic         ext_irq,
  input  logic [1:0]   sys_sel,
  output logic         exc,
  output logic [N-1:0] exc_vector,
  output logic [N-1:0] elr,
  output logic [3:0]   esr,
  output logic         ext_iack,
  output logic         in_handler,
  output logic         double_fault,
  output logic [N-1:0] sys_rd
);

  typedef enum logic [0:0] {StNormal, StHandler} state_e;

  localparam logic [3:0] EsrIrq    = 4'h1;
  localparam logic [3:0] EsrUndef  = 4'h2;
  localparam logic [3:0] EsrDouble = 4'hE;

  state_e             state_q, state_d;
  logic   [N-1:0]     elr_q, elr_d;
  logic   [3:0]       esr_q, esr_d;
  logic   [CNT_W-1:0] err_q, err_d;
  logic               iack_q, iack_d;
  logic               dfault_q, dfault_d;
  logic               bump_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StNormal;
      elr_q    <= '0;
      esr_q    <= '0;
      err_q    <= '0;
      iack_q   <= 1'b0;
      dfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      elr_q    <= elr_d;
      esr_q    <= esr_d;
      err_q    <= err_d;
      iack_q   <= iack_d;
      dfault_q <= dfault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    elr_d    = elr_q;
    esr_d    = esr_q;
    iack_d   = 1'b0;
    dfault_d = dfault_q;
    bump_err = 1'b0;
    exc      = 1'b0;
    unique case (state_q)
      StNormal: begin
        // An invalid opcode wins over an interrupt. The interrupt stays pending, unacked.
        if (NotAnInstr) begin
          exc      = 1'b1;
          elr_d    = pc_i;
          esr_d    = EsrUndef;
          bump_err = 1'b1;
          state_d  = StHandler;
        end else if (ext_irq) begin
          // elr holds the interrupted instruction, so it re-executes after ERET.
          exc      = 1'b1;
          elr_d    = pc_i;
          esr_d    = EsrIrq;
          iack_d   = 1'b1;
          bump_err = 1'b1;
          state_d  = StHandler;
        end
      end
      StHandler: begin
        // Interrupts are masked here. A fault re-vectors but keeps the original elr.
        if (NotAnInstr) begin
          exc      = 1'b1;
          esr_d    = EsrDouble;
          dfault_d = 1'b1;
          bump_err = 1'b1;
        end else if (ERet) begin
          state_d = StNormal;
        end
      end
      default: state_d = StNormal;
    endcase
    if (reset) begin
      exc = 1'b0;
    end
  end

  // The counter saturates at all-ones instead of wrapping.
  always_comb begin
    err_d = err_q;
    if (bump_err && (err_q != {CNT_W{1'b1}})) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  always_comb begin
    sys_rd = '0;
    unique case (sys_sel)
      2'b00:   sys_rd = elr_q;
      2'b01:   sys_rd = N'(esr_q);
      2'b10:   sys_rd = N'(err_q);
      default: sys_rd = '0;
    endcase
  end

  assign exc_vector   = EXC_VECTOR;
  assign elr          = elr_q;
  assign esr          = esr_q;
  assign ext_iack     = iack_q;
  assign in_handler   = (state_q == StHandler);
  assign double_fault = dfault_q;

endmodule
